// File: rtl/req_arbiter8.sv
// 8-requester arbiter with registered one-hot grant, hold-until-release, optional
// round-robin rotation and a hold-time watchdog that forces a turnaround bubble.
module req_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rr_mode,
    input  logic       release_i,
    output logic [7:0] gnt,
    output logic [2:0] gnt_code,
    output logic       gnt_valid,
    output logic       none_on,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_code_q, gnt_code_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             none_on_q, none_on_d;
    logic             timeout_q, timeout_d;
    logic [2:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]       winner;

    // Descending search from a start index with wrap; the start is (last-1) in
    // round-robin mode so the previous winner is visited last.
    function automatic logic [2:0] pick_winner(input logic [7:0] r,
                                               input logic       rr,
                                               input logic [2:0] last);
        logic [2:0] start;
        logic [2:0] idx;
        logic       found;
        start       = rr ? (last - 3'd1) : 3'd7;
        pick_winner = start;
        found       = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start - 3'(k);
            if (!found && r[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    assign winner = pick_winner(req, rr_mode, last_q);

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_code_d  = gnt_code_q;
        gnt_valid_d = gnt_valid_q;
        none_on_d   = none_on_q;
        timeout_d   = 1'b0;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_GRANT;
                    gnt_d       = 8'(1) << winner;
                    gnt_code_d  = winner;
                    gnt_valid_d = 1'b1;
                    none_on_d   = 1'b0;
                    hold_cnt_d  = CNT_W'(1);
                    last_d      = winner;
                end
            end
            ST_GRANT: begin
                if (release_i || !req[gnt_code_q] ||
                    (MAX_HOLD != 0 && hold_cnt_q == CNT_W'(MAX_HOLD))) begin
                    state_d     = ST_GAP;
                    gnt_d       = 8'h00;
                    gnt_code_d  = 3'd0;
                    gnt_valid_d = 1'b0;
                    none_on_d   = 1'b1;
                    hold_cnt_d  = '0;
                    // Release or owner drop takes precedence over the watchdog.
                    timeout_d   = !(release_i || !req[gnt_code_q]);
                end else if (!(&hold_cnt_q)) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 8'h00;
                gnt_code_d  = 3'd0;
                gnt_valid_d = 1'b0;
                none_on_d   = 1'b1;
                hold_cnt_d  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 8'h00;
            gnt_code_q  <= 3'd0;
            gnt_valid_q <= 1'b0;
            none_on_q   <= 1'b1;
            timeout_q   <= 1'b0;
            last_q      <= 3'd0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_code_q  <= gnt_code_d;
            gnt_valid_q <= gnt_valid_d;
            none_on_q   <= none_on_d;
            timeout_q   <= timeout_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_code  = gnt_code_q;
    assign gnt_valid = gnt_valid_q;
    assign none_on   = none_on_q;
    assign timeout   = timeout_q;

endmodule
